sprite_fetch: RTL and testbench



---
 rtl/sprite_fetch.sv | 127 ++++++++++++
 tb/tb_sprite_fetch.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_fetch.sv
// Sprite line fetch: on each scanline start, loads one 128-bit sprite row from BRAM, then emits one pixel per clock.
// Optional SPRITE_ZOOM2X_EN doubles the displayed sprite size in both axes.
module sprite_fetch #(
  parameter int AWIDTH   = 8,
  parameter int HV_WIDTH = 11
) (
  input  logic                clk,
  input  logic                reset_ni,
  input  logic [HV_WIDTH-1:0] sprite_x_i,
  input  logic [HV_WIDTH-1:0] sprite_y_i,
  input  logic                line_start_i,
  input  logic [HV_WIDTH-1:0] next_line_i,
  input  logic [HV_WIDTH-1:0] h_count_i,
  output logic                spr_rd_en_o,
  output logic [AWIDTH-1:0]   spr_rd_addr_o,
  input  logic [15:0]         spr_rd_data_i,
  output logic [3:0]          pixel_o,
  output logic                pixel_vis_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                state;
  logic [2:0]            k;
  logic [2:0]            cap_k;
  logic                  cap_vld;
  logic [4:0]            row_sel;
  logic [127:0]          line_buf;
  logic                  line_valid;
  logic [HV_WIDTH-1:0]   row;
  logic [HV_WIDTH-1:0]   dx;
  logic                  row_hit;
  logic [4:0]            row_idx;
  logic                  pix_hit;
  logic [4:0]            nib;
  logic [6:0]            wbase;
  logic [6:0]            nbase;
  logic [3:0]            nib_val;

  // Modular subtracts: lines above the sprite / columns left of it wrap to large values and miss.
  assign row = next_line_i - sprite_y_i;
  assign dx  = h_count_i - sprite_x_i;

`ifdef SPRITE_ZOOM2X_EN
  assign row_hit = row < HV_WIDTH'(64);
  assign row_idx = row[5:1];
  assign pix_hit = dx < HV_WIDTH'(64);
  assign nib     = dx[5:1];
`else
  assign row_hit = row < HV_WIDTH'(32);
  assign row_idx = row[4:0];
  assign pix_hit = dx < HV_WIDTH'(32);
  assign nib     = dx[4:0];
`endif

  assign spr_rd_addr_o = AWIDTH'({row_sel, k});
  assign wbase         = 7'd127 - {cap_k, 4'b0000};
  assign nbase         = 7'd127 - {nib, 2'b00};
  assign nib_val       = line_buf[nbase -: 4];

  // Read data returns one clock after the request; cap_vld/cap_k track which word is on the bus.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state       <= IDLE;
      k           <= '0;
      cap_k       <= '0;
      cap_vld     <= 1'b0;
      row_sel     <= '0;
      line_buf    <= '0;
      line_valid  <= 1'b0;
      spr_rd_en_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      cap_vld <= spr_rd_en_o;
      cap_k   <= k;
      if (cap_vld) line_buf[wbase -: 16] <= spr_rd_data_i;
      if (line_start_i) begin
        line_valid <= 1'b0;
        line_buf   <= '0;
        cap_vld    <= 1'b0;
        k          <= '0;
        row_sel    <= row_idx;
        if (row_hit) begin
          state       <= FETCH;
          spr_rd_en_o <= 1'b1;
          busy_o      <= 1'b1;
        end else begin
          state       <= IDLE;
          spr_rd_en_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      end else begin
        case (state)
          FETCH: begin
            if (k == 3'd7) begin
              state       <= DRAIN;
              spr_rd_en_o <= 1'b0;
            end else begin
              k <= k + 3'd1;
            end
          end
          DRAIN: begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            line_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      pixel_o     <= '0;
      pixel_vis_o <= 1'b0;
    end else if (line_valid && pix_hit) begin
      pixel_o     <= nib_val;
      pixel_vis_o <= |nib_val;
    end else begin
      pixel_o     <= '0;
      pixel_vis_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_fetch.sv
// Directed bench for sprite_fetch: fetch sequencing, abort/restart, pixel placement, clipping, reset.
module tb_sprite_fetch;
  localparam int HV = 11;
`ifdef SPRITE_ZOOM2X_EN
  localparam int SPAN = 64;
`else
  localparam int SPAN = 32;
`endif

  logic          clk = 1'b0;
  logic          reset_ni = 1'b0;
  logic [HV-1:0] sprite_x = 11'd200;
  logic [HV-1:0] sprite_y = 11'd100;
  logic          line_start = 1'b0;
  logic [HV-1:0] next_line = '0;
  logic [HV-1:0] h_count = '0;
  logic          rd_en;
  logic [7:0]    rd_addr;
  logic [15:0]   rd_data = '0;
  logic [3:0]    pixel;
  logic          vis;
  logic          busy;
  logic [15:0]   mem [256];
  int            checks = 0;
  int            failures = 0;

  sprite_fetch #(.AWIDTH(8), .HV_WIDTH(HV)) dut (
    .clk(clk), .reset_ni(reset_ni), .sprite_x_i(sprite_x), .sprite_y_i(sprite_y),
    .line_start_i(line_start), .next_line_i(next_line), .h_count_i(h_count),
    .spr_rd_en_o(rd_en), .spr_rd_addr_o(rd_addr), .spr_rd_data_i(rd_data),
    .pixel_o(pixel), .pixel_vis_o(vis), .busy_o(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rsel(input int r);
`ifdef SPRITE_ZOOM2X_EN
    return r / 2;
`else
    return r;
`endif
  endfunction

  function automatic logic [3:0] enib(input int base, input int d);
    int n;
    logic [15:0] w;
`ifdef SPRITE_ZOOM2X_EN
    n = d / 2;
`else
    n = d;
`endif
    w = mem[base + n / 4];
    return 4'((w >> (12 - 4 * (n % 4))) & 16'hF);
  endfunction

  // Called at a negedge; returns at the negedge of the first cycle after the pulse edge.
  task automatic pulse(input int nl);
    next_line  = HV'(nl);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic check_fetch(input int base);
    for (int j = 0; j < 8; j++) begin
      chk("fetch_en", rd_en, 1);
      chk("fetch_addr", rd_addr, base + j);
      chk("fetch_busy", busy, 1);
      @(negedge clk);
    end
    chk("drain_en", rd_en, 0);
    chk("drain_busy", busy, 1);
    @(negedge clk);
    chk("idle_busy", busy, 0);
  endtask

  task automatic pix(input string tag, input int h, input int ep, input int ev);
    h_count = HV'(h);
    @(negedge clk);
    chk({tag, "_pix"}, pixel, ep);
    chk({tag, "_vis"}, vis, ev);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h9E37 + 16'h1234);
    mem[0] = 16'h1230; mem[1] = 16'h4567; mem[4] = 16'hD000; mem[7] = 16'h89AB;
    mem[8'hF8] = 16'h5000; mem[8'hFF] = 16'h000C;

    repeat (3) @(negedge clk);
    chk("rst_en", rd_en, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pix", pixel, 0);
    chk("rst_vis", vis, 0);
    reset_ni = 1'b1;
    repeat (2) @(negedge clk);

    // Row 5: addresses row*8..row*8+7, busy through drain.
    pulse(105);
    check_fetch(rsel(5) * 8);

    // Row 0 with hand-placed words.
    @(negedge clk);
    pulse(100);
    repeat (12) @(negedge clk);
`ifndef SPRITE_ZOOM2X_EN
    pix("h200", 200, 1, 1);
    pix("h201", 201, 2, 1);
    pix("h202", 202, 3, 1);
    pix("h203", 203, 0, 0);
    pix("h199", 199, 0, 0);
    pix("h216", 216, 4'hD, 1);
    pix("h231", 231, 4'hB, 1);
    pix("h232", 232, 0, 0);
    sprite_x = 11'd2040;
    pix("clip_h2047", 2047, 7, 1);
    pix("clip_h2039", 2039, 0, 0);
    sprite_x = 11'd200;
`else
    pix("z_h200", 200, 1, 1);
    pix("z_h201", 201, 1, 1);
    pix("z_h202", 202, 2, 1);
    pix("z_h207", 207, 0, 0);
    pix("z_h264", 264, 0, 0);
`endif
    h_count = '0;

    // Line above sprite: row wraps, no reads, nothing visible.
    pulse(99);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (rd_en || busy) cnt++;
      @(negedge clk);
    end
    chk("off_reads", cnt, 0);
    cnt = 0;
    for (int d = -1; d <= SPAN; d++) begin
      h_count = HV'(200 + d);
      @(negedge clk);
      if (vis) cnt++;
    end
    chk("off_vis", cnt, 0);
    h_count = '0;

    // Restart mid-fetch: row 5 aborted at its fourth read, row 6 fetched clean.
    pulse(105);
    chk("ab_a0", rd_addr, rsel(5) * 8 + 0);
    @(negedge clk);
    chk("ab_a1", rd_addr, rsel(5) * 8 + 1);
    @(negedge clk);
    chk("ab_a2", rd_addr, rsel(5) * 8 + 2);
    @(negedge clk);
    chk("ab_a3", rd_addr, rsel(5) * 8 + 3);
    pulse(106);
    check_fetch(rsel(6) * 8);
    repeat (2) @(negedge clk);
    for (int d = 0; d < SPAN; d++) begin
      logic [3:0] e;
      e = enib(rsel(6) * 8, d);
      pix("row6", 200 + d, e, (e != 0) ? 1 : 0);
    end
    pix("row6_end", 200 + SPAN, 0, 0);
    h_count = '0;

`ifdef SPRITE_ZOOM2X_EN
    // Last doubled row fetches sprite row 31.
    pulse(100 + 63);
    check_fetch(8'hF8);
    repeat (2) @(negedge clk);
    pix("z_x0", 200, 5, 1);
    pix("z_x1", 201, 5, 1);
    pix("z_x63", 263, 4'hC, 1);
    pix("z_x64", 264, 0, 0);
    h_count = '0;
`endif

    // Asynchronous reset during a fetch.
    pulse(100);
    @(negedge clk);
    #2 reset_ni = 1'b0;
    #1;
    chk("mr_en", rd_en, 0);
    chk("mr_addr", rd_addr, 0);
    chk("mr_busy", busy, 0);
    chk("mr_vis", vis, 0);
    @(negedge clk);
    reset_ni = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (rd_en) cnt++;
      @(negedge clk);
    end
    chk("mr_no_reads", cnt, 0);
    pix("mr_h200", 200, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
